cache_port_arbiter: RTL and testbench
=====================================

Name: cache_port_arbiter

Overview:
- Shares the single dual-address cache read port between NUM_REQ requesters, e.g. the prefetcher FSM and a demand-load path.
- Round-robin arbitration with one outstanding transaction.
- Owns the cache_data_req / wait_cache / cache_data_ready handshake and routes returned data to the granted requester.
- Watchdog aborts transactions the cache never completes.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, read address width
DATA_W, 32, read data width
TIMEOUT, 255, max cycles from issue to data; 0 disables watchdog

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req_i  in  NUM_REQ  per-requester request level; addresses valid while high
req_addr0_i  in  NUM_REQ*ADDR_W  first read address, requester r at slice r
req_addr1_i  in  NUM_REQ*ADDR_W  second read address, requester r at slice r
gnt_o  out  NUM_REQ  one-hot, current transaction owner
rsp_valid_o  out  NUM_REQ  one-cycle completion pulse to owner
rsp_err_o  out  1  qualifies rsp_valid_o; 1 = watchdog abort
rsp_data0_o  out  DATA_W  returned data word 0
rsp_data1_o  out  DATA_W  returned data word 1
cache_data_req_o  out  1  read request to cache
cache_r_addr0_o  out  ADDR_W  latched address 0
cache_r_addr1_o  out  ADDR_W  latched address 1
wait_cache  in  1  cache stall; request accepted on an edge where this is 0
cache_data_ready  in  1  cache data valid this cycle
cache_data0_i  in  DATA_W  cache data word 0
cache_data1_i  in  DATA_W  cache data word 1
busy_o  out  1  high in ISSUE or WAIT_DATA

Behaviour:
- Reset (reset=0, async): state=IDLE, all outputs 0, watchdog 0, RR pointer set so requester 0 has highest priority.
- All outputs are registered.
- IDLE:
  - Exits only when some req_i bit is set and rsp_valid_o is 0. The cycle rsp_valid_o is high is a mandatory turnaround cycle.
  - Winner is the first set bit scanning upward (wrapping) from last_grant+1.
  - At that edge: latch winner's addresses into cache_r_addr*_o, set gnt_o, set cache_data_req_o=1, clear watchdog, go ISSUE.
  - Latency: req_i sampled at edge N, so gnt_o and cache_data_req_o are high from N+1.
- ISSUE:
  - cache_data_req_o and addresses held stable while wait_cache=1.
  - Edge with wait_cache=0: request accepted, cache_data_req_o goes 0, go WAIT_DATA.
  - If cache_data_ready=1 on the same accepting edge, complete immediately (see WAIT_DATA completion).
- WAIT_DATA:
  - Edge with cache_data_ready=1: latch cache_data*_i into rsp_data*_o, pulse rsp_valid_o[owner] for one cycle with rsp_err_o=0, clear gnt_o, set last_grant=owner, go IDLE.
  - cache_data_ready in IDLE is ignored.
- rsp_data*_o hold until the next completion.
- Requester handling:
  - A requester must hold req_i and its addresses stable until its rsp_valid_o pulse.
  - It must drop req_i in the pulse cycle unless it wants a further transaction.
  - Deasserting req_i after grant does not cancel the transaction.
- Watchdog (TIMEOUT>0):
  - Counter increments every cycle in ISSUE/WAIT_DATA.
  - When it equals TIMEOUT and no completion occurs on that edge: cache_data_req_o=0, rsp_valid_o[owner]=1, rsp_err_o=1, rsp_data*_o=0, update last_grant, go IDLE.
  - A completion on the same edge as expiry wins; it is a normal response.
  - Counter width is clog2(TIMEOUT+1), saturating.
- Reset asserted mid-transaction: immediate return to reset values. No response is generated, and requesters must reissue.
- busy_o = (state != IDLE).

Test Plan:
- Single requester: req_i=01, addr0=0x100, addr1=0x104, wait_cache=0, data_ready 3 cycles after issue with 0xAAAA/0x5555.
  - Expect gnt_o=01 at N+1, cache_data_req_o for exactly 1 cycle, rsp_valid_o=01 one cycle after data_ready, rsp_data0_o=0xAAAA, rsp_data1_o=0x5555, rsp_err_o=0.
- Contention: req_i=11 held for 4 transactions.
  - Expect grant order 0,1,0,1 and ≥1 idle cycle between consecutive cache_data_req_o assertions.
- Stall: wait_cache=1 for 5 cycles after issue.
  - Expect cache_data_req_o and addresses constant for 6 cycles, deasserted the edge after wait_cache falls.
- Accept+ready same edge: wait_cache=0 and cache_data_ready=1 on the first ISSUE edge.
  - Expect direct completion, no WAIT_DATA cycle, busy_o high exactly 1 cycle.
- Watchdog: TIMEOUT=8, cache never returns data.
  - Expect rsp_valid_o pulse with rsp_err_o=1 and data 0 at issue+8.
  - A late cache_data_ready in IDLE produces no pulse.
- Reset mid-op: assert reset in WAIT_DATA.
  - Expect all outputs 0 asynchronously (before next clk edge).
  - After release with req_i=11, requester 0 is granted first.

Source files
------------

// File: rtl/cache_port_arbiter_if.sv
// Bundles the requester-facing and cache-facing signals of the shared cache read port.
// The arbiter uses the slave view; the environment (requesters plus cache) uses the master view.
interface cache_port_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr0_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr1_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        rsp_valid_o;
    logic                      rsp_err_o;
    logic [DATA_W-1:0]         rsp_data0_o;
    logic [DATA_W-1:0]         rsp_data1_o;
    logic                      cache_data_req_o;
    logic [ADDR_W-1:0]         cache_r_addr0_o;
    logic [ADDR_W-1:0]         cache_r_addr1_o;
    logic                      wait_cache;
    logic                      cache_data_ready;
    logic [DATA_W-1:0]         cache_data0_i;
    logic [DATA_W-1:0]         cache_data1_i;
    logic                      busy_o;

    modport slave (
        input  req_i, req_addr0_i, req_addr1_i,
        input  wait_cache, cache_data_ready, cache_data0_i, cache_data1_i,
        output gnt_o, rsp_valid_o, rsp_err_o, rsp_data0_o, rsp_data1_o,
        output cache_data_req_o, cache_r_addr0_o, cache_r_addr1_o, busy_o
    );

    modport master (
        output req_i, req_addr0_i, req_addr1_i,
        output wait_cache, cache_data_ready, cache_data0_i, cache_data1_i,
        input  gnt_o, rsp_valid_o, rsp_err_o, rsp_data0_o, rsp_data1_o,
        input  cache_data_req_o, cache_r_addr0_o, cache_r_addr1_o, busy_o
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing one dual-address cache read port between NUM_REQ requesters,
// with one outstanding transaction and a watchdog that aborts reads the cache never completes.
module cache_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    cache_port_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t              r_state, w_state;
    logic [NUM_REQ-1:0]  r_gnt, w_gnt;
    logic [NUM_REQ-1:0]  r_vld, w_vld;
    logic                r_err, w_err;
    logic [DATA_W-1:0]   r_d0, w_d0, r_d1, w_d1;
    logic                r_creq, w_creq;
    logic [ADDR_W-1:0]   r_a0, w_a0, r_a1, w_a1;
    logic [IDX_W-1:0]    r_last, w_last, r_own, w_own;
    logic [WD_W-1:0]     r_wd, w_wd;
    logic                r_busy;
    logic                w_win_found;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_done, w_expire;

    // Scan upward from the requester after the last owner, wrapping around.
    always_comb begin : p_pick
        int                c;
        logic [IDX_W-1:0]  cidx;
        c           = 0;
        cidx        = '0;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c = int'(r_last) + k;
            if (c >= NUM_REQ) c = c - NUM_REQ;
            cidx = IDX_W'(c);
            if (!w_win_found && bus.req_i[cidx]) begin
                w_win_found = 1'b1;
                w_win_idx   = cidx;
            end
        end
    end

    always_comb begin
        w_state  = r_state;
        w_gnt    = r_gnt;
        w_vld    = '0;
        w_err    = 1'b0;
        w_d0     = r_d0;
        w_d1     = r_d1;
        w_creq   = r_creq;
        w_a0     = r_a0;
        w_a1     = r_a1;
        w_last   = r_last;
        w_own    = r_own;
        w_wd     = r_wd;
        w_done   = 1'b0;
        w_expire = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                // The cycle a response pulse is out is a forced turnaround.
                if (w_win_found && (r_vld == '0)) begin
                    w_state          = ST_ISSUE;
                    w_gnt            = '0;
                    w_gnt[w_win_idx] = 1'b1;
                    w_own            = w_win_idx;
                    w_creq           = 1'b1;
                    w_a0             = bus.req_addr0_i[int'(w_win_idx)*ADDR_W +: ADDR_W];
                    w_a1             = bus.req_addr1_i[int'(w_win_idx)*ADDR_W +: ADDR_W];
                    w_wd             = '0;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                w_wd     = (r_wd == WD_MAX) ? r_wd : r_wd + 1'b1;
                w_done   = bus.cache_data_ready && ((r_state == ST_WAIT) || !bus.wait_cache);
                w_expire = (TIMEOUT != 0) && (r_wd == WD_LAST);
                if (w_done || w_expire) begin
                    // A completion on the expiry edge is still a normal response.
                    w_state      = ST_IDLE;
                    w_vld[r_own] = 1'b1;
                    w_err        = !w_done;
                    w_d0         = w_done ? bus.cache_data0_i : '0;
                    w_d1         = w_done ? bus.cache_data1_i : '0;
                    w_gnt        = '0;
                    w_creq       = 1'b0;
                    w_last       = r_own;
                end else if ((r_state == ST_ISSUE) && !bus.wait_cache) begin
                    w_state = ST_WAIT;
                    w_creq  = 1'b0;
                end
            end
            default: w_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_vld   <= '0;
            r_err   <= 1'b0;
            r_d0    <= '0;
            r_d1    <= '0;
            r_creq  <= 1'b0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_own   <= '0;
            r_wd    <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_gnt   <= w_gnt;
            r_vld   <= w_vld;
            r_err   <= w_err;
            r_d0    <= w_d0;
            r_d1    <= w_d1;
            r_creq  <= w_creq;
            r_a0    <= w_a0;
            r_a1    <= w_a1;
            r_last  <= w_last;
            r_own   <= w_own;
            r_wd    <= w_wd;
            r_busy  <= (w_state != ST_IDLE);
        end
    end

    assign bus.gnt_o            = r_gnt;
    assign bus.rsp_valid_o      = r_vld;
    assign bus.rsp_err_o        = r_err;
    assign bus.rsp_data0_o      = r_d0;
    assign bus.rsp_data1_o      = r_d1;
    assign bus.cache_data_req_o = r_creq;
    assign bus.cache_r_addr0_o  = r_a0;
    assign bus.cache_r_addr1_o  = r_a1;
    assign bus.busy_o           = r_busy;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a transaction-level reference model.
module tb_cache_port_arbiter;
    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

    cache_port_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state: is a transaction open, who owns it, has the cache taken it, how old is it.
    bit            m_active;
    bit            m_sent;
    int            m_owner;
    int            m_age;
    int            m_last;
    logic [NR-1:0] e_gnt, e_vld;
    logic          e_err, e_creq;
    logic [DW-1:0] e_d0, e_d1;
    logic [AW-1:0] e_a0, e_a1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0; m_sent = 1'b0; m_owner = 0; m_age = 0; m_last = NR - 1;
        e_gnt = '0; e_vld = '0; e_err = 1'b0; e_creq = 1'b0;
        e_d0 = '0; e_d1 = '0; e_a0 = '0; e_a1 = '0;
    endtask

    task automatic model_edge();
        bit prev_vld;
        bit done;
        int c;
        prev_vld = (e_vld != '0);
        e_vld = '0;
        e_err = 1'b0;
        c = 0;
        if (!m_active) begin
            if (bus.req_i != '0 && !prev_vld) begin
                for (int k = 1; k <= NR; k++) begin
                    c = (m_last + k) % NR;
                    if (bus.req_i[c]) break;
                end
                m_active = 1'b1; m_sent = 1'b0; m_age = 0; m_owner = c;
                e_gnt = '0; e_gnt[c] = 1'b1; e_creq = 1'b1;
                e_a0 = bus.req_addr0_i[c*AW +: AW];
                e_a1 = bus.req_addr1_i[c*AW +: AW];
            end
        end else begin
            m_age++;
            done = bus.cache_data_ready && (m_sent || !bus.wait_cache);
            if (done || (TO > 0 && m_age == TO)) begin
                e_vld = '0; e_vld[m_owner] = 1'b1;
                e_err = !done;
                e_d0 = done ? bus.cache_data0_i : '0;
                e_d1 = done ? bus.cache_data1_i : '0;
                e_gnt = '0; e_creq = 1'b0;
                m_last = m_owner; m_active = 1'b0;
            end else if (!m_sent && !bus.wait_cache) begin
                m_sent = 1'b1; e_creq = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        chk("gnt",   bus.gnt_o,            e_gnt);
        chk("vld",   bus.rsp_valid_o,      e_vld);
        chk("err",   bus.rsp_err_o,        e_err);
        chk("data0", bus.rsp_data0_o,      e_d0);
        chk("data1", bus.rsp_data1_o,      e_d1);
        chk("creq",  bus.cache_data_req_o, e_creq);
        chk("addr0", bus.cache_r_addr0_o,  e_a0);
        chk("addr1", bus.cache_r_addr1_o,  e_a1);
        chk("busy",  bus.busy_o,           m_active);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int order[$];
        int rdy_div;
        bus.req_i = '0; bus.req_addr0_i = '0; bus.req_addr1_i = '0;
        bus.wait_cache = 1'b0; bus.cache_data_ready = 1'b0;
        bus.cache_data0_i = '0; bus.cache_data1_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;

        // Single requester, data three edges after issue
        bus.req_addr0_i[0 +: AW] = 32'h100;
        bus.req_addr1_i[0 +: AW] = 32'h104;
        bus.req_i = 2'b01;
        step();
        chk("t1_gnt", bus.gnt_o, 2'b01);
        chk("t1_creq_hi", bus.cache_data_req_o, 1'b1);
        step();
        chk("t1_creq_lo", bus.cache_data_req_o, 1'b0);
        step();
        bus.cache_data_ready = 1'b1; bus.cache_data0_i = 32'hAAAA; bus.cache_data1_i = 32'h5555;
        step();
        chk("t1_vld", bus.rsp_valid_o, 2'b01);
        chk("t1_d0", bus.rsp_data0_o, 32'hAAAA);
        chk("t1_d1", bus.rsp_data1_o, 32'h5555);
        chk("t1_err", bus.rsp_err_o, 1'b0);
        bus.cache_data_ready = 1'b0; bus.req_i = '0;
        step();

        // Stall: cache holds wait_cache for five edges
        bus.req_addr0_i[AW +: AW] = 32'h200;
        bus.req_addr1_i[AW +: AW] = 32'h208;
        bus.req_i = 2'b10;
        step();
        chk("st_creq0", bus.cache_data_req_o, 1'b1);
        bus.wait_cache = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("st_creq", bus.cache_data_req_o, 1'b1);
            chk("st_a0", bus.cache_r_addr0_o, 32'h200);
        end
        bus.wait_cache = 1'b0;
        step();
        chk("st_creq_drop", bus.cache_data_req_o, 1'b0);
        bus.cache_data_ready = 1'b1;
        step();
        chk("st_vld", bus.rsp_valid_o, 2'b10);
        bus.cache_data_ready = 1'b0; bus.req_i = '0;
        step();

        // Accept and ready on the same edge
        bus.req_i = 2'b01;
        step();
        chk("ar_busy1", bus.busy_o, 1'b1);
        bus.cache_data_ready = 1'b1; bus.cache_data0_i = 32'h1234; bus.cache_data1_i = 32'h5678;
        step();
        chk("ar_busy0", bus.busy_o, 1'b0);
        chk("ar_vld", bus.rsp_valid_o, 2'b01);
        chk("ar_d0", bus.rsp_data0_o, 32'h1234);
        bus.cache_data_ready = 1'b0; bus.req_i = '0;
        step();

        // Watchdog: cache never answers
        bus.req_i = 2'b10;
        step();
        cnt = 0;
        while (bus.rsp_valid_o == '0 && cnt < 20) begin
            step();
            cnt++;
        end
        chk("wd_latency", cnt, TO);
        chk("wd_vld", bus.rsp_valid_o, 2'b10);
        chk("wd_err", bus.rsp_err_o, 1'b1);
        chk("wd_d0", bus.rsp_data0_o, 32'h0);
        chk("wd_d1", bus.rsp_data1_o, 32'h0);
        bus.req_i = '0; bus.cache_data_ready = 1'b1;
        step();
        chk("late_rdy0", bus.rsp_valid_o, 2'b00);
        step();
        chk("late_rdy1", bus.rsp_valid_o, 2'b00);
        bus.cache_data_ready = 1'b0;

        // Reset while waiting for data
        bus.req_i = 2'b01;
        step();
        step();
        step();
        chk("rm_busy_pre", bus.busy_o, 1'b1);
        #3 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        bus.req_i = 2'b11;
        step();
        chk("rm_first_gnt", bus.gnt_o, 2'b01);

        // Contention: both requesters keep asking for four transactions
        for (int t = 0; t < 4; t++) begin
            order.push_back(bus.gnt_o[1] ? 1 : 0);
            bus.cache_data_ready = 1'b1;
            cnt = 0;
            while (bus.rsp_valid_o == '0 && cnt < 20) begin
                step();
                cnt++;
            end
            bus.cache_data_ready = 1'b0;
            if (t == 3) bus.req_i = '0;
            step();
            chk("ct_turnaround", bus.cache_data_req_o, 1'b0);
            step();
        end
        for (int t = 0; t < 4; t++) chk("ct_order", order[t], t % 2);

        // Randomized traffic with varying cache responsiveness
        bus.req_i = '0;
        for (int i = 0; i < 3000; i++) begin
            rdy_div = ((i / 500) % 3 == 0) ? 2 : (((i / 500) % 3 == 1) ? 4 : 12);
            bus.wait_cache       = ($urandom % 3) == 0;
            bus.cache_data_ready = ($urandom % rdy_div) == 0;
            bus.cache_data0_i    = $urandom;
            bus.cache_data1_i    = $urandom;
            step();
            for (int r = 0; r < NR; r++) begin
                if (!bus.req_i[r]) begin
                    if ($urandom % 4 == 0) begin
                        bus.req_addr0_i[r*AW +: AW] = $urandom;
                        bus.req_addr1_i[r*AW +: AW] = $urandom;
                        bus.req_i[r] = 1'b1;
                    end
                end else if (e_vld[r]) begin
                    if ($urandom % 3 == 0) begin
                        bus.req_addr0_i[r*AW +: AW] = $urandom;
                        bus.req_addr1_i[r*AW +: AW] = $urandom;
                    end else begin
                        bus.req_i[r] = 1'b0;
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
